kronos_scoreboard: RTL

Parametrised register scoreboard for the Kronos pipeline. It tracks up to `DEPTH` in-flight register writes across up to `NWB` independent writeback ports, and supports multiple writes outstanding to the same register. It stalls issue on read-after-write hazards and when the tracker is full. It sits between decode (issue handshake) and the register file write ports, and supersedes the single-entry pending-write tracker.

---
 rtl/kronos_scoreboard_if.sv | 33 +++
 rtl/kronos_scoreboard.sv | 96 +++++++++
 2 files changed

// File: rtl/kronos_scoreboard_if.sv
// Issue/writeback bundle between decode, the register file write ports and the scoreboard.
// The master drives the instruction and writeback fields. The slave returns stall, the pending count and the error flag.
interface kronos_scoreboard_if #(
    parameter int DEPTH = 4,
    parameter int NWB   = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     flush;
    logic                     issue_vld;
    logic                     issue_rdy;
    logic [4:0]               rs1;
    logic                     rs1_en;
    logic [4:0]               rs2;
    logic                     rs2_en;
    logic [4:0]               rd;
    logic                     rd_wr;
    logic [NWB-1:0][4:0]      wb_sel;
    logic [NWB-1:0]           wb_en;
    logic                     stall;
    logic [CW-1:0]            outstanding;
    logic                     wb_err;

    modport master (
        output flush, issue_vld, issue_rdy, rs1, rs1_en, rs2, rs2_en, rd, rd_wr, wb_sel, wb_en,
        input  stall, outstanding, wb_err
    );

    modport slave (
        input  flush, issue_vld, issue_rdy, rs1, rs1_en, rs2, rs2_en, rd, rd_wr, wb_sel, wb_en,
        output stall, outstanding, wb_err
    );
endinterface

// File: rtl/kronos_scoreboard.sv
// Multi-entry register scoreboard. It keeps a per-register count of pending writes and a total count.
// Issue stalls on RAW hazards and when the tracker is full. A writeback in the same cycle counts as a bypass.
module kronos_scoreboard #(
    parameter int DEPTH = 4,
    parameter int NWB   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    kronos_scoreboard_if.slave   sb
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_cnt [1:31];
    logic [CW-1:0] r_total;
    logic          r_wb_err;

    logic [CW-1:0] w_cnt_after [0:31];
    logic [CW-1:0] w_cnt_next  [1:31];
    logic [CW-1:0] w_dec       [1:31];
    logic [31:1]   w_over;
    logic [CW-1:0] w_dec_sum;
    logic [CW-1:0] w_total_after;
    logic          w_alloc_req;
    logic          w_rs1_haz;
    logic          w_rs2_haz;
    logic          w_full;
    logic          w_stall;
    logic          w_fire;
    logic          w_alloc;

    // x0 is never tracked, so its post-writeback count is tied to zero.
    assign w_cnt_after[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [3:0] w_hits;

            always_comb begin
                w_hits = '0;
                for (int p = 0; p < NWB; p++) begin
                    if (sb.wb_en[p] && (sb.wb_sel[p] == 5'(gi))) begin
                        w_hits = w_hits + 4'd1;
                    end
                end
            end

            // More hits than pending writes: retire only the pending ones and report the excess.
            assign w_over[gi]      = w_hits > 4'(r_cnt[gi]);
            assign w_dec[gi]       = w_over[gi] ? r_cnt[gi] : CW'(w_hits);
            assign w_cnt_after[gi] = r_cnt[gi] - w_dec[gi];
            assign w_cnt_next[gi]  = w_cnt_after[gi] + CW'(w_alloc && (sb.rd == 5'(gi)));
        end
    endgenerate

    always_comb begin
        w_dec_sum = '0;
        for (int r = 1; r < 32; r++) begin
            w_dec_sum = w_dec_sum + w_dec[r];
        end
    end

    assign w_total_after = r_total - w_dec_sum;
    assign w_alloc_req   = sb.rd_wr && (sb.rd != 5'd0);
    assign w_rs1_haz     = sb.rs1_en && (sb.rs1 != 5'd0) && (w_cnt_after[sb.rs1] != '0);
    assign w_rs2_haz     = sb.rs2_en && (sb.rs2 != 5'd0) && (w_cnt_after[sb.rs2] != '0);
    assign w_full        = w_alloc_req && (w_total_after == CW'(DEPTH));
    assign w_stall       = sb.issue_vld && (w_rs1_haz || w_rs2_haz || w_full);
    assign w_fire        = sb.issue_vld && sb.issue_rdy && !w_stall;
    assign w_alloc       = w_fire && w_alloc_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
            r_total  <= '0;
            r_wb_err <= 1'b0;
        end else if (sb.flush) begin
            for (int r = 1; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
            r_total <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                r_cnt[r] <= w_cnt_next[r];
            end
            r_total  <= w_total_after + CW'(w_alloc);
            r_wb_err <= r_wb_err | (|w_over);
        end
    end

    assign sb.stall       = w_stall;
    assign sb.outstanding = r_total;
    assign sb.wb_err      = r_wb_err;
endmodule
